// File: rtl/cpu_core_p.sv
// W-bit two-register CPU with a req/ack instruction fetch and a DEPTH-entry return stack.
// Each instruction takes one FETCH cycle plus one cycle per missing ack, then one EXEC cycle. A stack fault parks the core in HALT.
module cpu_core_p #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  output logic [W-1:0] imem_addr,
  output logic         imem_req,
  input  logic         imem_ack,
  input  logic [W+3:0] imem_data,
  input  logic [W-1:0] switch,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         halted
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ip_q, ip_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic           cf_q, cf_d, zf_q, zf_d, ov_q, ov_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [W+3:0]   ir_q, ir_d;
  logic [W-1:0]   stack_q [DEPTH];
  logic           push;

  logic [3:0]     op;
  logic [W-1:0]   imm, ip_inc;
  logic [W:0]     sum_a, sum_b;
  logic [W-1:0]   diff_a;
  logic [SPW-1:0] sp_dec;
  logic [IW-1:0]  push_idx, pop_idx;

  assign op       = ir_q[W+3:W];
  assign imm      = ir_q[W-1:0];
  assign ip_inc   = ip_q + W'(1);
  assign sum_a    = {1'b0, a_q} + {1'b0, imm};
  assign sum_b    = {1'b0, b_q} + {1'b0, imm};
  assign diff_a   = a_q - imm;
  assign sp_dec   = sp_q - SPW'(1);
  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = sp_dec[IW-1:0];

  // Qualified by reset so the request drops the instant n_reset falls.
  assign imem_req  = n_reset && (state_q == FETCH);
  assign imem_addr = ip_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    a_d     = a_q;
    b_d     = b_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    sp_d    = sp_q;
    ir_d    = ir_q;
    push    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        ip_d    = ip_inc;
        cf_d    = 1'b0;
        zf_d    = 1'b0;
        case (op)
          4'b0000: begin a_d = sum_a[W-1:0]; cf_d = sum_a[W]; zf_d = ~|sum_a[W-1:0]; end
          4'b0101: begin b_d = sum_b[W-1:0]; cf_d = sum_b[W]; zf_d = ~|sum_b[W-1:0]; end
          4'b1000: begin a_d = diff_a; cf_d = (a_q < imm); zf_d = ~|diff_a; end
          4'b0011: a_d = imm;
          4'b0111: b_d = imm;
          4'b0001: a_d = b_q;
          4'b0100: b_d = a_q;
          4'b0010: a_d = switch;
          4'b0110: b_d = switch;
          4'b1001: begin out_d = b_q; ov_d = 1'b1; end
          4'b1011: begin out_d = imm; ov_d = 1'b1; end
          4'b1111: ip_d = imm;
          4'b1110: if (!cf_q) ip_d = imm;
          4'b1101: if (zf_q) ip_d = imm;
          4'b1010: begin
            if (sp_q == SP_FULL) begin
              ip_d    = ip_q;
              state_d = HALT;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SPW'(1);
              ip_d = imm;
            end
          end
          default: begin
            if (sp_q == '0) begin
              ip_d    = ip_q;
              state_d = HALT;
            end else begin
              sp_d = sp_dec;
              ip_d = stack_q[pop_idx];
            end
          end
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= FETCH;
      ip_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      sp_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
    end
  end

  // Stack storage carries no reset; only sp defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= ip_inc;
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: instruction-level reference model driven by directed programs and random code.
module tb_cpu_core_p;
  localparam int W = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         n_reset;
  logic [W-1:0] imem_addr;
  logic         imem_req;
  logic         imem_ack;
  logic [W+3:0] imem_data;
  logic [W-1:0] sw;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         halted;

  cpu_core_p #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .switch(sw), .out_data(out_data), .out_valid(out_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [11:0] mem [256];
  logic [7:0]  m_ip, m_a, m_b, m_out;
  logic        m_cf, m_zf;
  bit          m_halt;
  logic [7:0]  m_stk [$];

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ip = 0; m_a = 0; m_b = 0; m_out = 0; m_cf = 0; m_zf = 0; m_halt = 0;
    m_stk.delete();
  endtask

  task automatic model_exec(input logic [11:0] w, input logic [7:0] swv, output logic ov);
    logic [3:0] op;
    logic [7:0] imm;
    logic       old_cf, old_zf;
    int         nip, t;
    op = w[11:8]; imm = w[7:0];
    old_cf = m_cf; old_zf = m_zf;
    m_cf = 0; m_zf = 0; ov = 0;
    nip = (int'(m_ip) + 1) % 256;
    case (op)
      4'h0: begin t = int'(m_a) + int'(imm); m_a = t[7:0]; m_cf = (t > 255); m_zf = (m_a == 0); end
      4'h5: begin t = int'(m_b) + int'(imm); m_b = t[7:0]; m_cf = (t > 255); m_zf = (m_b == 0); end
      4'h8: begin m_cf = (m_a < imm); t = (int'(m_a) - int'(imm) + 256) % 256; m_a = t[7:0]; m_zf = (m_a == 0); end
      4'h3: m_a = imm;
      4'h7: m_b = imm;
      4'h1: m_a = m_b;
      4'h4: m_b = m_a;
      4'h2: m_a = swv;
      4'h6: m_b = swv;
      4'h9: begin m_out = m_b; ov = 1; end
      4'hB: begin m_out = imm; ov = 1; end
      4'hF: nip = imm;
      4'hE: if (!old_cf) nip = imm;
      4'hD: if (old_zf) nip = imm;
      4'hA: if (m_stk.size() == DEPTH) begin m_halt = 1; nip = m_ip; end
            else begin m_stk.push_back(nip[7:0]); nip = imm; end
      default: if (m_stk.size() == 0) begin m_halt = 1; nip = m_ip; end
               else nip = m_stk.pop_back();
    endcase
    m_ip = nip[7:0];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_out"}, out_data, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 0; imem_ack = 0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    n_reset = 1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
  endtask

  // Reset pulse inside the current cycle, well before the next rising edge.
  task automatic inject_reset(input string tag);
    imem_ack = 0;
    #2 n_reset = 0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    model_reset();
    n_reset = 1;
    #1;
    chk({tag, "_refetch_req"}, imem_req, 1);
    chk({tag, "_refetch_addr"}, imem_addr, 0);
  endtask

  // One instruction: `waits` FETCH cycles without ack, then ack, then EXEC. swv < 0 -> random switch.
  task automatic step(input int waits, input int swv);
    logic [11:0] word;
    logic        exp_ov;
    if (m_halt) begin
      imem_ack = 0;
      chk("halt_req", imem_req, 0);
      chk("halt_flag", halted, 1);
      chk("halt_addr", imem_addr, m_ip);
      @(negedge clk);
      return;
    end
    for (int k = 0; k < waits; k++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_ip);
      if (k > 0) chk("ov_one_cycle", out_valid, 0);
      imem_ack = 0; imem_data = 12'($urandom);
      @(negedge clk);
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_ip);
    word = mem[m_ip];
    imem_ack = 1; imem_data = word;
    sw = (swv < 0) ? 8'($urandom) : 8'(swv);
    @(negedge clk);
    chk("exec_req", imem_req, 0);
    chk("exec_ov", out_valid, 0);
    imem_ack = 1'($urandom); imem_data = 12'($urandom);
    @(negedge clk);
    imem_ack = 0;
    model_exec(word, sw, exp_ov);
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, m_out);
    chk("halted", halted, m_halt);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
  endtask

  task automatic load_wrap();
    fill_random();
    mem[0] = ins(4'h3, 8'hFF); mem[1] = ins(4'h0, 8'h01); mem[2] = ins(4'hE, 8'h00);
    mem[3] = ins(4'hB, 8'h5A); mem[4] = ins(4'h4, 8'h00); mem[5] = ins(4'h9, 8'h00);
  endtask

  initial begin
    n_reset = 0; imem_ack = 0; imem_data = 0; sw = 0;
    model_reset();

    // Wraparound, ack in the first FETCH cycle.
    load_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, -1);
    chk("wrap_jnc_not_taken", imem_addr, 8'h03);
    step(0, -1);
    chk("wrap_out_imm", out_data, 8'h5A);
    chk("wrap_out_pulse", out_valid, 1);
    for (int i = 0; i < 2; i++) step(0, -1);
    chk("wrap_a_zero", out_data, 8'h00);

    // Same program with three wait states per fetch.
    do_reset();
    for (int i = 0; i < 6; i++) step(3, -1);
    chk("wait_a_zero", out_data, 8'h00);

    // SUB/JZ and borrow.
    fill_random();
    mem[8'h00] = ins(4'h3, 8'h03); mem[8'h01] = ins(4'h8, 8'h03); mem[8'h02] = ins(4'hD, 8'h10);
    mem[8'h10] = ins(4'h8, 8'h01); mem[8'h11] = ins(4'hE, 8'h00);
    mem[8'h12] = ins(4'h4, 8'h00); mem[8'h13] = ins(4'h9, 8'h00);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, -1);
    chk("jz_taken", imem_addr, 8'h10);
    step(0, -1); step(0, -1);
    chk("jnc_borrow_not_taken", imem_addr, 8'h12);
    step(0, -1); step(0, -1);
    chk("sub_wrap_a", out_data, 8'hFF);

    // Nested CALL/RET then RET on empty stack.
    fill_random();
    mem[8'h00] = ins(4'hA, 8'h20); mem[8'h20] = ins(4'hA, 8'h30); mem[8'h30] = ins(4'hA, 8'h40);
    mem[8'h40] = ins(4'hA, 8'h50); mem[8'h50] = ins(4'hC, 8'h00); mem[8'h41] = ins(4'hC, 8'h00);
    mem[8'h31] = ins(4'hC, 8'h00); mem[8'h21] = ins(4'hC, 8'h00); mem[8'h01] = ins(4'hB, 8'h77);
    mem[8'h02] = ins(4'hC, 8'h00);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, -1);
    chk("ret_lifo_1", imem_addr, 8'h41);
    for (int i = 0; i < 3; i++) step(0, -1);
    chk("ret_lifo_4", imem_addr, 8'h01);
    for (int i = 0; i < 2; i++) step(0, -1);
    chk("ret_empty_halt", halted, 1);
    for (int i = 0; i < 3; i++) step(0, -1);

    // Fifth nested CALL overflows.
    mem[8'h50] = ins(4'hA, 8'h60);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, -1);
    chk("call_ovf_halt", halted, 1);
    chk("call_ovf_ip", imem_addr, 8'h50);
    for (int i = 0; i < 3; i++) step(0, -1);

    // IN/OUT with a fixed switch value.
    fill_random();
    mem[0] = ins(4'h6, 8'h00); mem[1] = ins(4'h9, 8'h00); mem[2] = ins(4'h7, 8'h00);
    mem[3] = ins(4'h1, 8'h00);
    do_reset();
    step(0, 8'hA5); step(0, 8'h3C);
    chk("in_out_b", out_data, 8'hA5);
    chk("in_out_pulse", out_valid, 1);
    step(0, 8'h3C); step(0, 8'h3C);
    chk("out_held", out_data, 8'hA5);
    chk("out_no_pulse", out_valid, 0);

    // Async reset mid-FETCH (ack low), then mid-EXEC of a CALL with sp = 1.
    fill_random();
    mem[8'h00] = ins(4'hF, 8'h05); mem[8'h05] = ins(4'hB, 8'h33);
    do_reset();
    step(0, -1); step(2, -1);
    chk("pre_rst_out", out_data, 8'h33);
    inject_reset("rst_fetch");
    mem[8'h00] = ins(4'hA, 8'h20); mem[8'h20] = ins(4'hA, 8'h40);
    mem[8'h40] = ins(4'hC, 8'h00); mem[8'h21] = ins(4'hC, 8'h00); mem[8'h01] = ins(4'hC, 8'h00);
    step(0, -1);
    chk("exec_rst_fetch_addr", imem_addr, 8'h20);
    imem_ack = 1; imem_data = mem[8'h20];
    @(negedge clk);
    inject_reset("rst_exec");
    for (int i = 0; i < 5; i++) step(0, -1);
    chk("rst_sp_cleared", halted, 1);
    chk("rst_halt_ip", imem_addr, 8'h01);

    // Random code with random wait states against the model.
    fill_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halt) begin
        step(0, -1);
        fill_random();
        do_reset();
      end else begin
        step(int'($urandom_range(0, 3)), -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised successor of the 4-bit two-register CPU: W-bit A/B registers, W-bit instruction pointer, carry and zero flags, and a DEPTH-entry hardware return stack for CALL/RET. Instructions come from an external instruction memory over a req/ack fetch handshake, so multi-cycle ROMs and RAMs are supported. The block sits on the mother board between the program memory, the switch input and the LED/output port, and replaces the fixed single-cycle 4-bit core.

## Interface
- W, 8: data width, address width and immediate width; W ≥ 4.
- DEPTH, 4: return-stack entries; DEPTH ≥ 1.
- clk  in  1  single clock; all state updates on its rising edge.
- n_reset  in  1  asynchronous, active-low reset; clears all state immediately.
- imem_addr  out  W  fetch address; equals ip.
- imem_req  out  1  fetch request; high in FETCH only.
- imem_ack  in  1  memory has valid imem_data this cycle; may be high in the same cycle as imem_req.
- imem_data  in  W+4  instruction; [W+3:W] = opcode, [W-1:0] = imm.
- switch  in  W  input port, sampled in EXEC.
- out_data  out  W  output register, held between OUT instructions.
- out_valid  out  1  one-cycle pulse when out_data is written.
- halted  out  1  high in HALT.

## Operation
- States: FETCH, EXEC, HALT.
  - FETCH: imem_req = 1, imem_addr = ip. Hold until imem_ack. On ack: latch imem_data into ir; go to EXEC.
  - EXEC: execute ir; go to FETCH, or to HALT on a stack fault.
  - HALT: imem_req = 0; stay in HALT until reset.
- Default on every EXEC:
  - ip ← ip+1 (mod 2^W).
  - cf ← 0, zf ← 0.
  - a, b and out_data hold.
- Opcodes:
  - 0000 ADD A,imm: {cf,a} ← a+imm; zf ← (new a == 0).
  - 0101 ADD B,imm: {cf,b} ← b+imm; zf ← (new b == 0).
  - 1000 SUB A,imm: a ← a−imm (mod 2^W); cf ← (a < imm), i.e. borrow; zf ← (new a == 0).
  - 0011 MOV A,imm.
  - 0111 MOV B,imm.
  - 0001 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A: a ← switch.
  - 0110 IN B: b ← switch.
  - 1001 OUT B: out_data ← b; pulse out_valid.
  - 1011 OUT imm: out_data ← imm; pulse out_valid.
  - 1111 JMP imm: ip ← imm.
  - 1110 JNC imm: ip ← imm if cf == 0, else ip+1.
  - 1101 JZ imm: ip ← imm if zf == 1, else ip+1.
  - 1010 CALL imm:
    - Stack not full: stack[sp] ← ip+1 (mod 2^W); sp++; ip ← imm.
    - Stack full (sp == DEPTH): no push; a, b, ip unchanged; go to HALT.
  - 1100 RET:
    - Stack not empty: sp−−; ip ← stack[sp−1] (the entry just below the pre-decrement sp).
    - Stack empty (sp == 0): ip unchanged; go to HALT.
- Flag rule: JNC and JZ test the flags produced by the immediately preceding executed instruction. All non-arithmetic instructions clear both flags.
- sp width: clog2(DEPTH+1). Stack entries are not reset; only sp is.

## Timing
- Reset values while n_reset = 0:
  - state = FETCH; ip, a, b, cf, zf, sp = 0.
  - out_data = 0, out_valid = 0, halted = 0.
  - imem_req = 0 while reset is asserted.
  - imem_addr = 0.
- Reset asserted mid-fetch or mid-EXEC: the instruction is abandoned with no partial register update. imem_req drops asynchronously.
- First fetch: imem_req rises in the first cycle after n_reset deasserts, with imem_addr = 0.
- Throughput: 2 cycles per instruction when imem_ack is high in the first FETCH cycle. Each FETCH cycle without ack adds one cycle.
- imem_addr is stable for the whole FETCH state. imem_data is sampled only on the edge where imem_req && imem_ack.
- Register/flag/ip updates take effect on the edge that leaves EXEC.
- out_valid is high for exactly the cycle after that edge; out_data changes on the same edge.
- halted rises on the edge that leaves EXEC on a stack fault and stays high.

## Test plan
- Wraparound (W=8, ack tied high): MOV A,0xFF; ADD A,0x01; JNC 0x00; OUT imm 0x5A.
  - Expected: a = 0x00, cf = 1, zf = 1; the jump is not taken; out_data = 0x5A with a single out_valid pulse; 2 cycles per instruction.
- Wait states: ack delayed 3 cycles on every fetch.
  - Expected: imem_addr and imem_req held steady; 5 cycles per instruction; same architectural results as the no-wait run.
- SUB/JZ: MOV A,0x03; SUB A,0x03; JZ 0x10.
  - Expected: ip = 0x10.
  - Then SUB A,0x01 from a = 0: a = 0xFF, cf = 1, zf = 0; a following JNC is not taken.
- CALL/RET nesting (DEPTH=4):
  - Four nested CALLs followed by four RETs return to each call site +1, in LIFO order.
  - A fifth nested CALL sets halted; imem_req stays 0 afterwards.
  - RET with an empty stack also sets halted.
- IN/OUT: switch = 0xA5; IN B; OUT B.
  - Expected: out_data = 0xA5 with a one-cycle out_valid.
  - A further MOV B,0x00 with no OUT leaves out_data = 0xA5.
- Async reset: assert n_reset mid-FETCH with ack low, and again mid-EXEC of a CALL.
  - Expected: all outputs drop to their reset values immediately (without a clock edge); sp = 0; the next fetch after deassertion is from address 0.
